// File: rtl/up_amap_pkg.sv
// Shared types and constants for the up-bus address router.
package up_amap_pkg;

   typedef enum logic {StIdle, StWait} path_state_e;

   typedef enum logic [1:0] {DecSlave, DecStatus, DecErr} dec_e;

   localparam logic [31:0] Version        = 32'h0002_0000;
   localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;

   localparam int unsigned StatOffVersion = 0;
   localparam int unsigned StatOffTmoCnt  = 1;
   localparam int unsigned StatOffErrAddr = 2;
   localparam int unsigned StatOffDecCnt  = 3;

   function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] n);
      logic [16:0] s;
      s = {1'b0, v} + {15'b0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/up_amap_path.sv
// One request/ack channel: launches a single-cycle slave strobe and waits for the
// selected slave's ack or a timeout; non-slave requests are acked locally.
module up_amap_path
   import up_amap_pkg::*;
#(
   parameter int unsigned NumSlaves  = 24,
   parameter int unsigned IdxW       = 5,
   parameter int unsigned AddrW      = 14,
   parameter int unsigned SlaveAw    = 7,
   parameter int unsigned TimeoutCyc = 255,
   parameter logic [31:0] ErrData    = ErrDataDefault
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   input  dec_e                 dec_i,
   input  logic [IdxW-1:0]      idx_i,
   input  logic [AddrW-1:0]     addr_i,
   input  logic [31:0]          wdata_i,
   input  logic [31:0]          local_rdata_i,
   input  logic [0:NumSlaves-1] s_ack_i,
   input  logic [31:0]          s_rdata_i [0:NumSlaves-1],
   output logic                 busy_o,
   output logic                 ack_o,
   output logic [31:0]          rdata_o,
   output logic [0:NumSlaves-1] strobe_o,
   output logic [SlaveAw-1:0]   s_addr_o,
   output logic [31:0]          s_wdata_o,
   output logic                 tmo_o,
   output logic [AddrW-1:0]     addr_o
);

   path_state_e      state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             strobe_q, strobe_d;
   logic             ack_q, ack_d;
   logic [15:0]      cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      ack_d    = 1'b0;
      rdata_d  = '0;
      tmo_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               if (dec_i == DecSlave) begin
                  state_d  = StWait;
                  idx_d    = idx_i;
                  addr_d   = addr_i;
                  wdata_d  = wdata_i;
                  strobe_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  ack_d   = 1'b1;
                  rdata_d = local_rdata_i;
               end
            end
         end
         StWait: begin
            // An ack in the final counted cycle still wins over the timeout.
            if (s_ack_i[idx_q]) begin
               state_d = StIdle;
               ack_d   = 1'b1;
               rdata_d = s_rdata_i[idx_q];
            end else if (cnt_q == 16'(TimeoutCyc)) begin
               state_d = StIdle;
               ack_d   = 1'b1;
               rdata_d = ErrData;
               tmo_o   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         strobe_q <= 1'b0;
         ack_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         strobe_q <= strobe_d;
         ack_q    <= ack_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NumSlaves; i++) begin
         strobe_o[i] = strobe_q && (idx_q == IdxW'(i));
      end
   end

   assign busy_o    = (state_q == StWait);
   assign ack_o     = ack_q;
   assign rdata_o   = rdata_q;
   assign s_addr_o  = addr_q[SlaveAw-1:0];
   assign s_wdata_o = wdata_q;
   assign addr_o    = addr_q;

endmodule

// File: rtl/up_amap_router.sv
// Up-bus router: decodes board/type/offset, fans out to per-board slaves and keeps
// timeout/decode-error counters readable at the all-ones board index.
module up_amap_router
   import up_amap_pkg::*;
#(
   parameter int unsigned NUM_OF_BOARD = 6,
   parameter int unsigned NUM_OF_SLAVE = 4,
   parameter int unsigned ADDR_WIDTH   = 14,
   parameter int unsigned SLAVE_AW     = 7,
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [31:0] ERR_DATA     = ErrDataDefault
) (
   input  logic                                 up_clk,
   input  logic                                 up_rstn,
   input  logic                                 up_wreq,
   input  logic [ADDR_WIDTH-1:0]                up_waddr,
   input  logic [31:0]                          up_wdata,
   output logic                                 up_wack,
   input  logic                                 up_rreq,
   input  logic [ADDR_WIDTH-1:0]                up_raddr,
   output logic [31:0]                          up_rdata,
   output logic                                 up_rack,
   output logic [0:NUM_OF_BOARD*NUM_OF_SLAVE-1] s_up_wreq,
   output logic [SLAVE_AW-1:0]                  s_up_waddr [0:NUM_OF_BOARD*NUM_OF_SLAVE-1],
   output logic [31:0]                          s_up_wdata [0:NUM_OF_BOARD*NUM_OF_SLAVE-1],
   input  logic [0:NUM_OF_BOARD*NUM_OF_SLAVE-1] s_up_wack,
   output logic [0:NUM_OF_BOARD*NUM_OF_SLAVE-1] s_up_rreq,
   output logic [SLAVE_AW-1:0]                  s_up_raddr [0:NUM_OF_BOARD*NUM_OF_SLAVE-1],
   input  logic [31:0]                          s_up_rdata [0:NUM_OF_BOARD*NUM_OF_SLAVE-1],
   input  logic [0:NUM_OF_BOARD*NUM_OF_SLAVE-1] s_up_rack
);

   localparam int unsigned TYPE_W  = $clog2(NUM_OF_SLAVE);
   localparam int unsigned BOARD_W = ADDR_WIDTH - SLAVE_AW - TYPE_W;
   localparam int unsigned NS      = NUM_OF_BOARD * NUM_OF_SLAVE;
   localparam int unsigned IDX_W   = $clog2(NS);
   localparam logic [BOARD_W-1:0] StatusBoard = {BOARD_W{1'b1}};

   function automatic dec_e decode(input logic [BOARD_W-1:0] board);
      if (board == StatusBoard) return DecStatus;
      if (32'(board) < NUM_OF_BOARD) return DecSlave;
      return DecErr;
   endfunction

   dec_e              r_dec, w_dec;
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic [31:0]       status_rdata, r_local_rdata;
   logic              r_busy, w_busy, r_tmo, w_tmo;
   logic [ADDR_WIDTH-1:0] r_tmo_addr, w_tmo_addr;
   logic [SLAVE_AW-1:0]   r_saddr, w_saddr;
   logic [31:0]       w_swdata, unused_r_wdata, unused_w_rdata;
   logic              r_dec_ev, w_dec_ev, cnt_clr;
   logic [15:0]       tmo_cnt_q, tmo_cnt_d, dec_cnt_q, dec_cnt_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   assign r_dec = decode(up_raddr[ADDR_WIDTH-1 -: BOARD_W]);
   assign w_dec = decode(up_waddr[ADDR_WIDTH-1 -: BOARD_W]);
   // NUM_OF_SLAVE is a power of two, so the flat index is just {board, type}.
   assign r_idx = IDX_W'(up_raddr[ADDR_WIDTH-1:SLAVE_AW]);
   assign w_idx = IDX_W'(up_waddr[ADDR_WIDTH-1:SLAVE_AW]);

   always_comb begin
      status_rdata = '0;
      case (up_raddr[SLAVE_AW-1:0])
         SLAVE_AW'(StatOffVersion): status_rdata = Version;
         SLAVE_AW'(StatOffTmoCnt):  status_rdata = {16'b0, tmo_cnt_q};
         SLAVE_AW'(StatOffErrAddr): status_rdata = 32'(err_addr_q);
         SLAVE_AW'(StatOffDecCnt):  status_rdata = {16'b0, dec_cnt_q};
         default:                   status_rdata = '0;
      endcase
   end

   assign r_local_rdata = (r_dec == DecStatus) ? status_rdata : ERR_DATA;

   // Requests only count when the path is idle; a busy path drops them.
   assign r_dec_ev = up_rreq && !r_busy && (r_dec == DecErr);
   assign w_dec_ev = up_wreq && !w_busy && (w_dec == DecErr);
   assign cnt_clr  = up_wreq && !w_busy && (w_dec == DecStatus) &&
                     (up_waddr[SLAVE_AW-1:0] == SLAVE_AW'(StatOffTmoCnt));

   always_comb begin
      tmo_cnt_d  = cnt_clr ? '0 : sat_add(tmo_cnt_q, {1'b0, r_tmo} + {1'b0, w_tmo});
      dec_cnt_d  = cnt_clr ? '0 : sat_add(dec_cnt_q, {1'b0, r_dec_ev} + {1'b0, w_dec_ev});
      err_addr_d = err_addr_q;
      if (r_dec_ev)      err_addr_d = up_raddr;
      else if (r_tmo)    err_addr_d = r_tmo_addr;
      else if (w_dec_ev) err_addr_d = up_waddr;
      else if (w_tmo)    err_addr_d = w_tmo_addr;
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         tmo_cnt_q  <= '0;
         dec_cnt_q  <= '0;
         err_addr_q <= '0;
      end else begin
         tmo_cnt_q  <= tmo_cnt_d;
         dec_cnt_q  <= dec_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   up_amap_path #(
      .NumSlaves  (NS),
      .IdxW       (IDX_W),
      .AddrW      (ADDR_WIDTH),
      .SlaveAw    (SLAVE_AW),
      .TimeoutCyc (TIMEOUT),
      .ErrData    (ERR_DATA)
   ) u_rd_path (
      .clk_i         (up_clk),
      .rst_ni        (up_rstn),
      .req_i         (up_rreq),
      .dec_i         (r_dec),
      .idx_i         (r_idx),
      .addr_i        (up_raddr),
      .wdata_i       (32'h0),
      .local_rdata_i (r_local_rdata),
      .s_ack_i       (s_up_rack),
      .s_rdata_i     (s_up_rdata),
      .busy_o        (r_busy),
      .ack_o         (up_rack),
      .rdata_o       (up_rdata),
      .strobe_o      (s_up_rreq),
      .s_addr_o      (r_saddr),
      .s_wdata_o     (unused_r_wdata),
      .tmo_o         (r_tmo),
      .addr_o        (r_tmo_addr)
   );

   up_amap_path #(
      .NumSlaves  (NS),
      .IdxW       (IDX_W),
      .AddrW      (ADDR_WIDTH),
      .SlaveAw    (SLAVE_AW),
      .TimeoutCyc (TIMEOUT),
      .ErrData    (ERR_DATA)
   ) u_wr_path (
      .clk_i         (up_clk),
      .rst_ni        (up_rstn),
      .req_i         (up_wreq),
      .dec_i         (w_dec),
      .idx_i         (w_idx),
      .addr_i        (up_waddr),
      .wdata_i       (up_wdata),
      .local_rdata_i (32'h0),
      .s_ack_i       (s_up_wack),
      .s_rdata_i     (s_up_rdata),
      .busy_o        (w_busy),
      .ack_o         (up_wack),
      .rdata_o       (unused_w_rdata),
      .strobe_o      (s_up_wreq),
      .s_addr_o      (w_saddr),
      .s_wdata_o     (w_swdata),
      .tmo_o         (w_tmo),
      .addr_o        (w_tmo_addr)
   );

   always_comb begin
      for (int i = 0; i < NS; i++) begin
         s_up_waddr[i] = w_saddr;
         s_up_wdata[i] = w_swdata;
         s_up_raddr[i] = r_saddr;
      end
   end

endmodule
